// File: rtl/spin_pkg.sv
// Shared definitions for the spin clock generator:
// mode encodings, FSM states and default half-periods.
package spin_pkg;

    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [1:0] MODE_FAST = 2'b01;
    localparam logic [1:0] MODE_MED  = 2'b10;
    localparam logic [1:0] MODE_SLOW = 2'b11;

    localparam logic [31:0] D_FAST_DEF = 32'd1000000;
    localparam logic [31:0] D_MED_DEF  = 32'd5000000;
    localparam logic [31:0] D_SLOW_DEF = 32'd8000000;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/spin_div_counter.sv
// Half-period counter with clear, enable and a terminal flag
// against a runtime divisor; wraps to zero on terminal.
module spin_div_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] div_i,
    output logic             term_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign term_o = en_i && (cnt_q == div_i - WIDTH'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || term_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spin_clock_gen.sv
// Mode-selectable 50% duty clock divider; mode changes and
// stop requests take effect only at half-period boundaries.
module spin_clock_gen
    import spin_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter logic [31:0] D_FAST = D_FAST_DEF,
    parameter logic [31:0] D_MED  = D_MED_DEF,
    parameter logic [31:0] D_SLOW = D_SLOW_DEF
) (
    input  logic       cin,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    output logic       cout,
    output logic       tick,
    output logic [1:0] active_mode
);

    if (D_FAST == 32'd0 || D_MED == 32'd0 || D_SLOW == 32'd0 ||
        (64'(D_FAST) >> WIDTH) != 64'd0 ||
        (64'(D_MED) >> WIDTH) != 64'd0 ||
        (64'(D_SLOW) >> WIDTH) != 64'd0) begin : g_bad_param
        $error("spin_clock_gen: divisor parameter out of range");
    end

    localparam logic [WIDTH-1:0] DF_W = WIDTH'(D_FAST);
    localparam logic [WIDTH-1:0] DM_W = WIDTH'(D_MED);
    localparam logic [WIDTH-1:0] DS_W = WIDTH'(D_SLOW);

    state_t           state_q, state_d;
    logic             cout_q, cout_d;
    logic             tick_q, tick_d;
    logic [1:0]       act_q, act_d;
    logic [WIDTH-1:0] div;
    logic             term;
    logic             start;

    always_comb begin
        case (act_q)
            MODE_MED:  div = DM_W;
            MODE_SLOW: div = DS_W;
            default:   div = DF_W;
        endcase
    end

    spin_div_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk_i  (cin),
        .rst_i  (rst),
        .clr_i  (state_q == S_IDLE),
        .en_i   (en && (state_q == S_RUN)),
        .div_i  (div),
        .term_o (term)
    );

    assign start = en && (mode != MODE_STOP);

    always_ff @(posedge cin) begin
        if (rst) begin
            state_q <= S_IDLE;
            cout_q  <= 1'b0;
            tick_q  <= 1'b0;
            act_q   <= MODE_STOP;
        end else begin
            state_q <= state_d;
            cout_q  <= cout_d;
            tick_q  <= tick_d;
            act_q   <= act_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (term && mode == MODE_STOP) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A stop request parks cout low; tick only if that is a real edge.
    always_comb begin
        cout_d = cout_q;
        tick_d = 1'b0;
        act_d  = act_q;
        case (state_q)
            S_IDLE: begin
                if (start) act_d = mode;
            end
            S_RUN: begin
                if (term) begin
                    if (mode == MODE_STOP) begin
                        cout_d = 1'b0;
                        tick_d = cout_q;
                        act_d  = MODE_STOP;
                    end else begin
                        cout_d = ~cout_q;
                        tick_d = 1'b1;
                        act_d  = mode;
                    end
                end
            end
            default: ;
        endcase
    end

    assign cout        = cout_q;
    assign tick        = tick_q;
    assign active_mode = act_q;

endmodule

// File: tb/tb_spin_clock_gen.sv
// Self-checking bench for spin_clock_gen: directed scenarios plus
// random traffic against a countdown-to-toggle reference model.
module tb_spin_clock_gen;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [1:0] mode;
    logic       cout, tick;
    logic [1:0] act;

    logic       rst_b, en_b;
    logic [1:0] mode_b;
    logic       cout_b, tick_b;
    logic [1:0] act_b;

    int errors = 0;
    int checks = 0;

    logic       m_run = 1'b0;
    logic       m_cout = 1'b0;
    logic       m_tick = 1'b0;
    logic [1:0] m_act = 2'b00;
    int         m_rem = 0;

    always #5 clk = ~clk;

    spin_clock_gen #(
        .WIDTH (8), .D_FAST (32'd2), .D_MED (32'd5), .D_SLOW (32'd8)
    ) dut (
        .cin (clk), .rst (rst), .en (en), .mode (mode),
        .cout (cout), .tick (tick), .active_mode (act)
    );

    spin_clock_gen #(
        .WIDTH (8), .D_FAST (32'd1), .D_MED (32'd3), .D_SLOW (32'd4)
    ) dut_b (
        .cin (clk), .rst (rst_b), .en (en_b), .mode (mode_b),
        .cout (cout_b), .tick (tick_b), .active_mode (act_b)
    );

    function automatic int d_of(input logic [1:0] m);
        case (m)
            2'b01:   return 2;
            2'b10:   return 5;
            default: return 8;
        endcase
    endfunction

    // Model: cycles remaining until the next toggle of the half-period.
    task automatic model_edge();
        m_tick = 1'b0;
        if (rst) begin
            m_run = 1'b0; m_cout = 1'b0; m_act = 2'b00; m_rem = 0;
        end else if (en && !m_run) begin
            if (mode != 2'b00) begin
                m_run = 1'b1; m_act = mode; m_rem = d_of(mode);
            end
        end else if (en) begin
            m_rem--;
            if (m_rem == 0) begin
                if (mode == 2'b00) begin
                    m_tick = m_cout; m_cout = 1'b0;
                    m_run = 1'b0; m_act = 2'b00;
                end else begin
                    m_tick = 1'b1; m_cout = ~m_cout;
                    m_act = mode; m_rem = d_of(mode);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; mode = 2'b00;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 2'b11;
        rst_b = 1'b1; en_b = 1'b0; mode_b = 2'b00;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({cout, tick, act} !== 4'b0000) begin
                errors++;
                $display("FAIL reset k=%0d got c=%b t=%b a=%0d want 0 0 0",
                         k, cout, tick, act);
            end
        end
    endtask

    task automatic test_fast();
        logic ec, et;
        rst = 1'b0; en = 1'b1; mode = 2'b01;
        for (int k = 0; k <= 12; k++) begin
            step();
            ec = 1'((k / 2) % 2);
            et = (k > 0) && (k % 2 == 0);
            checks++;
            if ({cout, tick, act} !== {ec, et, 2'b01} ||
                {cout, tick, act} !== {m_cout, m_tick, m_act}) begin
                errors++;
                $display("FAIL fast k=%0d got c=%b t=%b a=%0d want %b %b 1",
                         k, cout, tick, act, ec, et);
            end
        end
    endtask

    task automatic test_mode_switch();
        logic ec, et;
        do_reset();
        en = 1'b1; mode = 2'b01;
        step();
        step();
        mode = 2'b11;
        for (int k = 2; k <= 18; k++) begin
            step();
            ec = (k >= 2 && k < 10) || k >= 18;
            et = (k == 2 || k == 10 || k == 18);
            checks++;
            if ({cout, tick, act} !== {ec, et, 2'b11} ||
                {cout, tick, act} !== {m_cout, m_tick, m_act}) begin
                errors++;
                $display("FAIL switch k=%0d got c=%b t=%b a=%0d want %b %b 3",
                         k, cout, tick, act, ec, et);
            end
        end
    endtask

    task automatic test_stop();
        logic ec, et;
        logic [1:0] ea;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            en = 1'b1; mode = 2'b10;
            for (int k = 0; k <= 18; k++) begin
                step();
                if (k == (pass == 0 ? 6 : 11)) mode = 2'b00;
                ec = (k >= 5 && k < 10);
                et = (k == 5 || k == 10);
                ea = (k < (pass == 0 ? 10 : 15)) ? 2'b10 : 2'b00;
                checks++;
                if ({cout, tick, act} !== {ec, et, ea} ||
                    {cout, tick, act} !== {m_cout, m_tick, m_act}) begin
                    errors++;
                    $display("FAIL stop%0d k=%0d got c=%b t=%b a=%0d want %b %b %0d",
                             pass, k, cout, tick, act, ec, et, ea);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic ec, et;
        do_reset();
        en = 1'b1; mode = 2'b11;
        for (int k = 0; k <= 20; k++) begin
            step();
            if (k == 4) en = 1'b0;
            if (k == 7) en = 1'b1;
            ec = (k >= 11 && k < 19);
            et = (k == 11 || k == 19);
            checks++;
            if ({cout, tick, act} !== {ec, et, 2'b11} ||
                {cout, tick, act} !== {m_cout, m_tick, m_act}) begin
                errors++;
                $display("FAIL stall k=%0d got c=%b t=%b a=%0d want %b %b 3",
                         k, cout, tick, act, ec, et);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic ec, et;
        logic [1:0] ea;
        do_reset();
        en = 1'b1; mode = 2'b11;
        for (int k = 0; k <= 22; k++) begin
            step();
            rst = (k == 11);
            ec = (k >= 8 && k < 12) || k >= 21;
            et = (k == 8 || k == 21);
            ea = (k == 12) ? 2'b00 : 2'b11;
            checks++;
            if ({cout, tick, act} !== {ec, et, ea} ||
                {cout, tick, act} !== {m_cout, m_tick, m_act}) begin
                errors++;
                $display("FAIL rstmid k=%0d got c=%b t=%b a=%0d want %b %b %0d",
                         k, cout, tick, act, ec, et, ea);
            end
        end
    endtask

    task automatic test_d1();
        logic ec, et;
        rst_b = 1'b1;
        step();
        rst_b = 1'b0; en_b = 1'b1; mode_b = 2'b01;
        for (int k = 0; k <= 8; k++) begin
            step();
            ec = 1'(k % 2);
            et = (k > 0);
            checks++;
            if ({cout_b, tick_b, act_b} !== {ec, et, 2'b01}) begin
                errors++;
                $display("FAIL d1 k=%0d got c=%b t=%b a=%0d want %b %b 1",
                         k, cout_b, tick_b, act_b, ec, et);
            end
        end
        mode_b = 2'b00;
        step();
        checks++;
        if ({cout_b, tick_b, act_b} !== 4'b0000) begin
            errors++;
            $display("FAIL d1_stop got c=%b t=%b a=%0d want 0 0 0",
                     cout_b, tick_b, act_b);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 99) < 2);
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            step();
            checks++;
            if ({cout, tick, act} !== {m_cout, m_tick, m_act}) begin
                errors++;
                $display("FAIL random k=%0d got c=%b t=%b a=%0d want %b %b %0d",
                         k, cout, tick, act, m_cout, m_tick, m_act);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00;
        rst_b = 1'b1; en_b = 1'b0; mode_b = 2'b00;
        test_reset();
        test_fast();
        test_mode_switch();
        test_stop();
        test_stall();
        test_rst_mid();
        test_d1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
